// File: rtl/load_store_unit_if.sv
// Datapath request/response and data-RAM signals of the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    // datapath request side
    logic                  i_req;
    logic                  i_we;
    logic [1:0]            i_size;
    logic                  i_unsigned;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    // datapath response side
    logic                  o_busy;
    logic                  o_done;
    logic                  o_misaligned;
    logic [DATA_WIDTH-1:0] o_rdata;
    // data RAM side
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_data;
    logic                  o_MemWrite;
    logic                  o_MemRead;
    logic [DATA_WIDTH-1:0] i_mem_data;

    // datapath + RAM model side
    modport master (
        output i_req, i_we, i_size, i_unsigned, i_addr, i_wdata, i_mem_data,
        input  o_busy, o_done, o_misaligned, o_rdata,
               o_mem_addr, o_mem_data, o_MemWrite, o_MemRead
    );

    // load/store unit side
    modport slave (
        input  i_req, i_we, i_size, i_unsigned, i_addr, i_wdata, i_mem_data,
        output o_busy, o_done, o_misaligned, o_rdata,
               o_mem_addr, o_mem_data, o_MemWrite, o_MemRead
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed requests to word RAM accesses with
// read-modify-write for sub-word stores, load lane extension and alignment checks.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    load_store_unit_if.slave  bus
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = ADDR_WIDTH;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic          we;
        logic [1:0]    size;
        logic          uns;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t        state_q, state_d;
    req_t          req_q, req_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          mis_q, mis_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          mem_write_q, mem_write_d;
    logic          mem_read_q, mem_read_d;

    logic          misaligned_c;
    logic [4:0]    shamt_c;
    logic [DW-1:0] lane_c;
    logic [DW-1:0] load_ext_c;
    logic [DW-1:0] mask_c;
    logic [DW-1:0] merged_c;

    // alignment check on the incoming request
    always_comb begin
        misaligned_c = 1'b0;
        case (bus.i_size)
            SIZE_BYTE: misaligned_c = 1'b0;
            SIZE_HALF: misaligned_c = bus.i_addr[0];
            SIZE_WORD: misaligned_c = (bus.i_addr[1:0] != 2'b00);
            default:   misaligned_c = 1'b1;
        endcase
    end

    // lane extraction/extension for loads and lane merge for sub-word stores
    always_comb begin
        shamt_c    = {req_q.addr[1:0], 3'b000};
        lane_c     = bus.i_mem_data >> shamt_c;
        load_ext_c = bus.i_mem_data;
        case (req_q.size)
            SIZE_BYTE: load_ext_c = {{(DW-8){~req_q.uns & lane_c[7]}}, lane_c[7:0]};
            SIZE_HALF: load_ext_c = {{(DW-16){~req_q.uns & lane_c[15]}}, lane_c[15:0]};
            default:   load_ext_c = bus.i_mem_data;
        endcase
        mask_c   = ((req_q.size == SIZE_BYTE) ? DW'(8'hFF) : DW'(16'hFFFF)) << shamt_c;
        merged_c = (bus.i_mem_data & ~mask_c) | ((req_q.wdata << shamt_c) & mask_c);
    end

    // next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        mis_d       = 1'b0;
        mem_addr_d  = '0;
        mem_data_d  = '0;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req) begin
                    req_d.we    = bus.i_we;
                    req_d.size  = bus.i_size;
                    req_d.uns   = bus.i_unsigned;
                    req_d.addr  = bus.i_addr;
                    req_d.wdata = bus.i_wdata;
                    if (misaligned_c) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else if (bus.i_we && (bus.i_size == SIZE_WORD)) begin
                        state_d     = ST_WR;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {2'b00, bus.i_addr[AW-1:2]};
                        mem_data_d  = bus.i_wdata;
                    end else begin
                        state_d    = ST_RD;
                        mem_read_d = 1'b1;
                        mem_addr_d = {2'b00, bus.i_addr[AW-1:2]};
                    end
                end
            end
            ST_RD: begin
                if (req_q.we) begin
                    state_d     = ST_WR;
                    mem_write_d = 1'b1;
                    mem_addr_d  = mem_addr_q;
                    mem_data_d  = merged_c;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    rdata_d = load_ext_c;
                end
            end
            ST_WR: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // state, latched request and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_misaligned = mis_q;
    assign bus.o_rdata      = rdata_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_data   = mem_data_q;
    assign bus.o_MemWrite   = mem_write_q;
    assign bus.o_MemRead    = mem_read_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// requests against a byte-level reference memory model.
module tb_load_store_unit;
    logic clk;
    logic rst_n;
    logic ram_init;

    load_store_unit_if bus ();

    load_store_unit u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write at the rising edge
    logic [31:0] mem [64];
    logic [5:0]  mem_idx;
    assign mem_idx        = bus.o_mem_addr[5:0];
    assign bus.i_mem_data = mem[mem_idx];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int n = 0; n < 64; n++) mem[n] <= 32'(n + 1);
        end else if (bus.o_MemWrite) begin
            mem[mem_idx] <= bus.o_mem_data;
        end
    end

    // reference state
    logic [31:0] ref_mem [64];
    logic [31:0] ref_rdata;

    int tests_run;
    int tests_failed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1) return (addr % 2) != 0;
        if (size == 2'd2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    // load value from the bytes of a word, little-endian
    function automatic logic [31:0] model_load(input logic [31:0] w, input int off,
                                               input logic [1:0] size, input logic uns);
        logic [7:0]  b [4];
        logic [31:0] v;
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        if (size == 2'd0) begin
            v = {24'h0, b[off]};
            if (!uns && b[off][7]) v = v | 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = {16'h0, b[off+1], b[off]};
            if (!uns && b[off+1][7]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // word after storing the low byte(s) of wd at byte offset off
    function automatic logic [31:0] model_store(input logic [31:0] w, input int off,
                                                input logic [1:0] size, input logic [31:0] wd);
        logic [7:0]  b [4];
        logic [31:0] v;
        if (size == 2'd2) return wd;
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        b[off] = wd[7:0];
        if (size == 2'd1) b[off+1] = wd[15:8];
        for (int k = 0; k < 4; k++) v[8*k +: 8] = b[k];
        return v;
    endfunction

    // issue one request and check its whole response against the model
    task automatic run_op(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic        mis;
        int          idx;
        int          off;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] new_word;
        int          cyc;
        int          done_cyc;
        int          rd_cnt;
        int          wr_cnt;
        logic        got_mis;
        logic [31:0] got_rdata;

        mis      = is_mis(size, addr);
        idx      = int'(addr / 4);
        off      = int'(addr % 4);
        exp_lat  = mis ? 1 : (!we ? 2 : (size == 2'd2 ? 2 : 3));
        exp_rd   = (!mis && (!we || size != 2'd2)) ? 1 : 0;
        exp_wr   = (!mis && we) ? 1 : 0;
        new_word = model_store(ref_mem[idx], off, size, wdata);

        @(negedge clk);
        check({tag, " idle"}, {30'h0, bus.o_busy, bus.o_done}, 32'h0);
        bus.i_req      = 1'b1;
        bus.i_we       = we;
        bus.i_size     = size;
        bus.i_unsigned = uns;
        bus.i_addr     = addr;
        bus.i_wdata    = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.i_req = 1'b0;

        cyc = 1; done_cyc = 0; rd_cnt = 0; wr_cnt = 0;
        got_mis = 1'b0; got_rdata = 32'h0;
        while (cyc <= 8) begin
            if (bus.o_MemRead && bus.o_MemWrite)
                check({tag, " both_strobes"}, 32'h1, 32'h0);
            if (bus.o_MemRead) begin
                rd_cnt++;
                check({tag, " rd_addr"}, bus.o_mem_addr, 32'(idx));
            end
            if (bus.o_MemWrite) begin
                wr_cnt++;
                check({tag, " wr_addr"}, bus.o_mem_addr, 32'(idx));
                check({tag, " wr_data"}, bus.o_mem_data, new_word);
            end
            if (!bus.o_MemRead && !bus.o_MemWrite && (bus.o_mem_addr != 0 || bus.o_mem_data != 0))
                check({tag, " idle_bus"}, bus.o_mem_addr | bus.o_mem_data, 32'h0);
            if (bus.o_done) begin
                done_cyc  = cyc;
                got_mis   = bus.o_misaligned;
                got_rdata = bus.o_rdata;
                check({tag, " busy_in_done"}, 32'(bus.o_busy), 32'h1);
                break;
            end
            @(negedge clk);
            cyc++;
        end

        if (!mis && exp_wr == 1) ref_mem[idx] = new_word;
        if (!mis && !we) ref_rdata = model_load(ref_mem[idx], off, size, uns);

        check({tag, " latency"}, 32'(done_cyc), 32'(exp_lat));
        check({tag, " misaligned"}, 32'(got_mis), 32'(mis));
        check({tag, " rdata"}, got_rdata, ref_rdata);
        check({tag, " rd_count"}, 32'(rd_cnt), 32'(exp_rd));
        check({tag, " wr_count"}, 32'(wr_cnt), 32'(exp_wr));
    endtask

    initial begin
        int   n_done;
        int   first_done;
        int   second_done;
        logic [1:0]  r_size;
        logic [31:0] r_addr;

        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        ram_init = 1'b1;
        bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_size = 2'b00; bus.i_unsigned = 1'b0;
        bus.i_addr = 32'h0; bus.i_wdata = 32'h0;
        for (int n = 0; n < 64; n++) ref_mem[n] = 32'(n + 1);
        ref_rdata = 32'h0;

        repeat (3) @(negedge clk);
        check("reset_flags", {27'h0, bus.o_busy, bus.o_done, bus.o_misaligned,
                               bus.o_MemRead, bus.o_MemWrite}, 32'h0);
        check("reset_rdata", bus.o_rdata, 32'h0);
        check("reset_bus", bus.o_mem_addr | bus.o_mem_data, 32'h0);
        ram_init = 1'b0;
        rst_n = 1'b1;

        // directed cases from the plan
        run_op("lw_8",   1'b0, 2'd2, 1'b0, 32'h8,  32'h0);
        run_op("sb_5",   1'b1, 2'd0, 1'b0, 32'h5,  32'h12);
        run_op("lw_4",   1'b0, 2'd2, 1'b0, 32'h4,  32'h0);
        check("sb_merge_word", ref_rdata, 32'h00001202);
        run_op("sw_c",   1'b1, 2'd2, 1'b0, 32'hC,  32'h000080FF);
        run_op("lb_c",   1'b0, 2'd0, 1'b0, 32'hC,  32'h0);
        run_op("lbu_c",  1'b0, 2'd0, 1'b1, 32'hC,  32'h0);
        run_op("lh_c",   1'b0, 2'd1, 1'b0, 32'hC,  32'h0);
        run_op("lhu_c",  1'b0, 2'd1, 1'b1, 32'hC,  32'h0);
        run_op("lb_d",   1'b0, 2'd0, 1'b0, 32'hD,  32'h0);
        check("lb_d_value", ref_rdata, 32'hFFFFFF80);
        run_op("mis_lw6",  1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
        run_op("mis_lh3",  1'b0, 2'd1, 1'b0, 32'h3, 32'h0);
        run_op("mis_sz3",  1'b1, 2'd3, 1'b0, 32'h0, 32'hDEAD);

        // request held high: one accept, then a second in the IDLE after DONE
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_size = 2'd2; bus.i_unsigned = 1'b0;
        bus.i_addr = 32'h0; bus.i_wdata = 32'h0;
        @(posedge clk);
        n_done = 0; first_done = 0; second_done = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (bus.o_done) begin
                n_done++;
                if (n_done == 1) first_done = k;
                if (n_done == 2) second_done = k;
                check("held_rdata", bus.o_rdata, 32'h1);
            end
            if (k == 5) bus.i_req = 1'b0;
        end
        ref_rdata = 32'h1;
        check("held_done_count", 32'(n_done), 32'd2);
        check("held_first_done", 32'(first_done), 32'd2);
        check("held_second_done", 32'(second_done), 32'd5);

        // reset during the write phase of a halfword store
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_size = 2'd1; bus.i_unsigned = 1'b0;
        bus.i_addr = 32'h10; bus.i_wdata = 32'h0000BEEF;
        @(posedge clk);
        @(negedge clk);
        bus.i_req = 1'b0;
        check("rst_sh_rd", 32'(bus.o_MemRead), 32'h1);
        @(posedge clk);
        #2;
        check("rst_sh_wr", 32'(bus.o_MemWrite), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_strobes", {30'h0, bus.o_MemRead, bus.o_MemWrite}, 32'h0);
        check("rst_busy", 32'(bus.o_busy), 32'h0);
        n_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.o_done) n_done++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (bus.o_done) n_done++;
        end
        check("rst_no_done", 32'(n_done), 32'h0);
        ref_rdata = 32'h0;
        check("rst_rdata", bus.o_rdata, 32'h0);
        run_op("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lw_10_value", ref_rdata, 32'h00000005);

        // random traffic
        for (int t = 0; t < 80; t++) begin
            r_size = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && r_size == 2'd3) r_size = 2'd2;
            r_addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 2) != 0) begin
                if (r_size == 2'd1) r_addr = r_addr & 32'hFE;
                if (r_size == 2'd2) r_addr = r_addr & 32'hFC;
            end
            run_op("rand", 1'($urandom_range(0, 1)), r_size, 1'($urandom_range(0, 1)),
                   r_addr, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
